vram_port_arbiter: RTL and testbench
====================================

Name: vram_port_arbiter

Overview:
- Arbitrates the single CPU-side port (port A) of the dual-port video RAM between two requesters: the pipeline MEM stage (scalar or vector access, already muxed) and a burst DMA engine used by the cryptography/transfer path.
- Serialises all accesses onto the port and stalls the pipeline while it is not granted.
- Routes read data back to whichever requester issued the read, after the fixed RAM read latency.
- Port B (VGA scan-out) is untouched.

Parameters:
- ADDR_W, 17, word address width.
- DATA_W, 32, data width.
- NUM_WORDS, 76800, number of valid RAM words (used only by the optional feature).
- RD_LAT, 2, cycles from address presented on ram_addr to valid ram_rdata (registered address plus registered output).
- STARVE_MAX, 15, number of consecutive cycles a pending DMA request may lose to the CPU before it is forced through.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request (level).
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_stall  out  1  CPU request pending but not granted this cycle.
- cpu_rvalid  out  1  CPU read data valid (1-cycle pulse).
- cpu_rdata  out  DATA_W  CPU read data.
- dma_req  in  1  start-burst request (level; held until dma_busy).
- dma_we  in  1  burst direction: 1=write, 0=read.
- dma_base  in  ADDR_W  burst start address.
- dma_len  in  8  burst beats; 0 means 256.
- dma_wdata  in  DATA_W  write data for the current beat.
- dma_beat  out  1  beat issued this cycle; dma_wdata consumed.
- dma_rvalid  out  1  DMA read data valid.
- dma_rdata  out  DATA_W  DMA read data.
- dma_busy  out  1  burst in progress.
- dma_done  out  1  1-cycle pulse after the last beat is issued.
- ram_we  out  1  port A write enable.
- ram_addr  out  ADDR_W  port A address.
- ram_wdata  out  DATA_W  port A data in.
- ram_rdata  in  DATA_W  port A data out.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high on all flops.
- Reset values: all outputs 0, FSM=IDLE, starve counter=0, read-tag pipe cleared. Reset mid-burst abandons the burst: no dma_done, and in-flight reads produce no rvalid.

FSM states: IDLE, DMA_BURST, DMA_DONE.
- IDLE, cpu_req=1 and (dma_req=0 or starve<STARVE_MAX): CPU granted combinationally this cycle.
  - ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata, cpu_stall=0.
  - If dma_req=1, starve increments, saturating at STARVE_MAX.
- IDLE, dma_req=1 and (cpu_req=0 or starve==STARVE_MAX): burst starts.
  - Latch base/len/we; beat counter=len (0 loads 256); starve cleared; go to DMA_BURST.
  - No beat is issued in this cycle. cpu_stall=cpu_req.
- IDLE, no request: ram_we=0, ram_addr holds its last value.
- DMA_BURST, each cycle:
  - Issue one beat: ram_addr=current address, ram_we=latched we, ram_wdata=dma_wdata, dma_beat=1.
  - Address increments modulo 2^ADDR_W.
  - Counter decrements; after the last beat go to DMA_DONE.
  - Burst is not preemptible. cpu_stall=cpu_req throughout.
- DMA_DONE: dma_done=1 for one cycle, ram_we=0, CPU not granted (cpu_stall=cpu_req), go to IDLE.
  - In the following IDLE cycle the CPU wins if requesting, even if dma_req is already high again.
- dma_busy=1 in DMA_BURST and DMA_DONE.

Read return:
- An RD_LAT-deep shift register carries tag {valid, owner} for every read issued.
- At the output end of the pipe: if owner=CPU, pulse cpu_rvalid with cpu_rdata=ram_rdata. If owner=DMA, pulse dma_rvalid with dma_rdata=ram_rdata.
- Writes insert valid=0. Back-to-back reads from alternating owners return in issue order, one per cycle.
- rdata outputs hold their value when rvalid=0.

Write/read ordering: a write followed next cycle by a read to the same address returns the new data (port A read-during-write is new-data; the bench models it that way).

Optional Feature:
- Macro: VRAM_ADDR_CHECK_EN.
- Defined:
  - Any issued access with address >= NUM_WORDS is suppressed: ram_we forced to 0.
  - A read to such an address returns rvalid with rdata=0.
  - Sticky output addr_err (1 bit, reset 0) is set and is cleared only by reset.
  - DMA bursts crossing NUM_WORDS flag the error on the first offending beat and continue.
- Undefined: no range check and no addr_err port. Addresses pass through unmodified.

Test Plan:
- CPU write 0x1234ABCD to addr 5, then CPU read addr 5 -> ram_we=1 with addr 5 in cycle 0; cpu_rvalid exactly 2 cycles after the read is issued, cpu_rdata=0x1234ABCD; cpu_stall=0 throughout.
- DMA write burst base=0x1FFFE, len=4 -> dma_beat for 4 consecutive cycles at addrs 0x1FFFE, 0x1FFFF, 0x00000, 0x00001; dma_done pulses 1 cycle after the last beat; a CPU request held throughout sees cpu_stall=1 for all 6 cycles (start + 4 beats + done).
- cpu_req held high continuously with dma_req=1 -> CPU granted 15 cycles, the burst starts on cycle 16; after DMA_DONE the CPU wins the first IDLE cycle.
- Alternating CPU read addr 10 then DMA burst read len=2 at addr 20 -> cpu_rvalid and dma_rvalid arrive in issue order, each carrying its own RAM contents; never both high in the same cycle.
- dma_len=0 -> exactly 256 beats, then dma_done.
- reset asserted mid-burst (beat 3 of 8) -> all outputs 0 asynchronously; no dma_done; no rvalid afterwards. With VRAM_ADDR_CHECK_EN, a CPU write to 76800 -> ram_we=0, addr_err=1 and sticky until reset.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: serialises the pipeline MEM stage and the burst DMA
// engine onto port A of the video RAM, and steers read data back to the
// requester that issued each read.
// Optional address range checking (addr_err port) is built when the macro
// VRAM_ADDR_CHECK_EN is defined.
module vram_port_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_WORDS  = 76800,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_base,
  input  logic [7:0]        dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_beat,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_ADDR_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned CW = 9;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

`ifdef VRAM_ADDR_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DMA_BURST = 2'd1,
    DMA_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SW-1:0]       r_starve;
  logic [SW-1:0]       w_starve_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                r_dma_we;
  logic                w_dma_we_nxt;
  logic [ADDR_W-1:0]   r_last_addr;
  logic [DATA_W-1:0]   r_last_wdata;
  logic [RD_LAT-1:0]   r_tag_v;
  logic [RD_LAT-1:0]   r_tag_own;
  logic [RD_LAT-1:0]   r_tag_z;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_dma_rdata;

  logic                w_issue;
  logic                w_iss_we;
  logic                w_iss_own;
  logic [ADDR_W-1:0]   w_iss_addr;
  logic [DATA_W-1:0]   w_iss_wdata;
  logic                w_stall;
  logic                w_oob;
  logic                w_ram_we_int;
  logic                w_ret_cpu;
  logic                w_ret_dma;
  logic [DATA_W-1:0]   w_ret_data;

  // Arbitration FSM next state and the access presented on port A
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    w_addr_nxt   = r_addr;
    w_cnt_nxt    = r_cnt;
    w_dma_we_nxt = r_dma_we;
    w_issue      = 1'b0;
    w_iss_we     = 1'b0;
    w_iss_own    = 1'b0;
    w_iss_addr   = r_last_addr;
    w_iss_wdata  = r_last_wdata;
    w_stall      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cpu_req && (!dma_req || (r_starve < STARVE_LIM))) begin
          w_issue     = 1'b1;
          w_iss_we    = cpu_we;
          w_iss_addr  = cpu_addr;
          w_iss_wdata = cpu_wdata;
          if (dma_req && (r_starve != STARVE_LIM)) begin
            w_starve_nxt = r_starve + SW'(1);
          end
        end else if (dma_req) begin
          // Latch the burst; the first beat goes out next cycle
          w_addr_nxt   = dma_base;
          w_cnt_nxt    = (dma_len == 8'd0) ? CW'(256) : CW'(dma_len);
          w_dma_we_nxt = dma_we;
          w_starve_nxt = '0;
          w_stall      = cpu_req;
          w_state_nxt  = DMA_BURST;
        end
      end
      DMA_BURST: begin
        w_issue     = 1'b1;
        w_iss_we    = r_dma_we;
        w_iss_own   = 1'b1;
        w_iss_addr  = r_addr;
        w_iss_wdata = dma_wdata;
        w_addr_nxt  = r_addr + ADDR_W'(1);
        w_cnt_nxt   = r_cnt - CW'(1);
        w_stall     = cpu_req;
        if (r_cnt == CW'(1)) begin
          w_state_nxt = DMA_DONE;
        end
      end
      DMA_DONE: begin
        w_stall     = cpu_req;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Out-of-range detection; constant zero when range checking is not built
  always_comb begin
    w_oob        = RANGE_CHECK && (32'(w_iss_addr) >= NUM_WORDS);
    w_ram_we_int = w_issue & w_iss_we & ~w_oob;
  end

  // State, burst context, last port A value and read-tag pipe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_starve     <= '0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_dma_we     <= 1'b0;
      r_last_addr  <= '0;
      r_last_wdata <= '0;
      r_tag_v      <= '0;
      r_tag_own    <= '0;
      r_tag_z      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve     <= w_starve_nxt;
      r_addr       <= w_addr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dma_we     <= w_dma_we_nxt;
      r_last_addr  <= w_iss_addr;
      r_last_wdata <= w_iss_wdata;
      r_tag_v[0]   <= w_issue & ~w_iss_we;
      r_tag_own[0] <= w_iss_own;
      r_tag_z[0]   <= w_oob;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
        r_tag_z[i]   <= r_tag_z[i-1];
      end
    end
  end

  // Read return steering at the output end of the tag pipe
  always_comb begin
    w_ret_cpu  = r_tag_v[RD_LAT-1] & ~r_tag_own[RD_LAT-1];
    w_ret_dma  = r_tag_v[RD_LAT-1] & r_tag_own[RD_LAT-1];
    w_ret_data = r_tag_z[RD_LAT-1] ? '0 : ram_rdata;
  end

  // Hold the last returned read data per requester
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      if (w_ret_cpu) r_cpu_rdata <= w_ret_data;
      if (w_ret_dma) r_dma_rdata <= w_ret_data;
    end
  end

`ifdef VRAM_ADDR_CHECK_EN
  logic r_addr_err;

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_err <= 1'b0;
    end else if (w_issue && w_oob) begin
      r_addr_err <= 1'b1;
    end
  end

  assign addr_err = r_addr_err;
`endif

  // Grant-path outputs are forced low while reset is asserted
  assign ram_we     = ~reset & w_ram_we_int;
  assign ram_addr   = reset ? '0 : w_iss_addr;
  assign ram_wdata  = reset ? '0 : w_iss_wdata;
  assign cpu_stall  = ~reset & w_stall;
  assign cpu_rvalid = w_ret_cpu;
  assign cpu_rdata  = w_ret_cpu ? w_ret_data : r_cpu_rdata;
  assign dma_rvalid = w_ret_dma;
  assign dma_rdata  = w_ret_dma ? w_ret_data : r_dma_rdata;
  assign dma_beat   = (r_state == DMA_BURST);
  assign dma_busy   = (r_state != IDLE);
  assign dma_done   = (r_state == DMA_DONE);

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a 2-cycle port A RAM model.
module tb_vram_port_arbiter;

`ifdef VRAM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int unsigned LIMIT = 76800;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [16:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [16:0] dma_base;
  logic [7:0]  dma_len;
  logic [31:0] dma_wdata;
  logic        dma_beat, dma_rvalid, dma_busy, dma_done;
  logic [31:0] dma_rdata;
  logic        ram_we;
  logic [16:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
`ifdef VRAM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int nb;
  bit seen_done;
  logic [16:0] ea;

  vram_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_base   (dma_base),
    .dma_len    (dma_len),
    .dma_wdata  (dma_wdata),
    .dma_beat   (dma_beat),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .dma_busy   (dma_busy),
    .dma_done   (dma_done),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
`ifdef VRAM_ADDR_CHECK_EN
    ,
    .addr_err   (addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port A model: registered address, registered output, preset contents
  logic [31:0] mem [0:131071];
  logic [16:0] m_addr_q = '0;
  bit          m_init = 1'b0;
  always @(posedge clk) begin
    if (!m_init) begin
      for (int i = 0; i < 131072; i++) mem[i] = 32'hA500_0000 ^ 32'(i);
      m_init = 1'b1;
    end
    ram_rdata <= mem[m_addr_q];
    if (ram_we) mem[ram_addr] = ram_wdata;
    m_addr_q <= ram_addr;
  end

  function automatic logic [31:0] pat(input int a);
    return 32'hA500_0000 ^ 32'(a);
  endfunction

  function automatic logic exp_we(input logic [16:0] a);
    return !CHK || (32'(a) < LIMIT);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd5; cpu_wdata = 32'hFFFF_FFFF;
    dma_req = 1'b0; dma_we = 1'b0; dma_base = '0; dma_len = '0; dma_wdata = '0;
    #1;
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_busy", dma_busy, 0);
    chk("rst_dma_beat", dma_beat, 0);
    chk("rst_dma_done", dma_done, 0);
    chk("rst_dma_rvalid", dma_rvalid, 0);
`ifdef VRAM_ADDR_CHECK_EN
    chk("rst_addr_err", addr_err, 0);
`endif
    @(negedge clk);
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);

    // CPU write then read of address 5
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd5; cpu_wdata = 32'h1234_ABCD;
    #1;
    chk("t1_wr_we", ram_we, 1);
    chk("t1_wr_addr", ram_addr, 5);
    chk("t1_wr_data", ram_wdata, 32'h1234_ABCD);
    chk("t1_wr_stall", cpu_stall, 0);
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    chk("t1_rd_we", ram_we, 0);
    chk("t1_rd_addr", ram_addr, 5);
    chk("t1_rd_stall", cpu_stall, 0);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("t1_rv_early", cpu_rvalid, 0);
    @(negedge clk);
    #1;
    chk("t1_rvalid", cpu_rvalid, 1);
    chk("t1_rdata", cpu_rdata, 32'h1234_ABCD);
    chk("t1_no_dma_rv", dma_rvalid, 0);
    @(negedge clk);
    #1;
    chk("t1_rv_off", cpu_rvalid, 0);
    chk("t1_rdata_hold", cpu_rdata, 32'h1234_ABCD);

    // Starvation: CPU wins 15 cycles, then the wrapping DMA write burst runs
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd7;
      dma_req = 1'b1; dma_we = 1'b1; dma_base = 17'h1FFFE; dma_len = 8'd4;
      #1;
      chk("t3_grant_stall", cpu_stall, 0);
      chk("t3_grant_addr", ram_addr, 7);
      chk("t3_grant_busy", dma_busy, 0);
    end
    @(negedge clk);
    #1;
    chk("t2_start_stall", cpu_stall, 1);
    chk("t2_start_beat", dma_beat, 0);
    chk("t2_start_we", ram_we, 0);
    chk("t2_start_rv", cpu_rvalid, 1);
    chk("t2_start_rdata", cpu_rdata, pat(7));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dma_req = 1'b0; dma_wdata = 32'hCAFE_0000 + 32'(k);
      ea = 17'h1FFFE + 17'(k);
      #1;
      chk("t2_beat", dma_beat, 1);
      chk("t2_beat_addr", ram_addr, ea);
      chk("t2_beat_we", ram_we, exp_we(ea));
      chk("t2_beat_wdata", ram_wdata, 32'hCAFE_0000 + 32'(k));
      chk("t2_beat_stall", cpu_stall, 1);
      chk("t2_beat_busy", dma_busy, 1);
    end
    @(negedge clk);
    dma_req = 1'b1; dma_we = 1'b0; dma_base = 17'd300; dma_len = 8'd1;
    #1;
    chk("t2_done", dma_done, 1);
    chk("t2_done_stall", cpu_stall, 1);
    chk("t2_done_we", ram_we, 0);
    chk("t2_done_beat", dma_beat, 0);
    chk("t2_done_busy", dma_busy, 1);
    @(negedge clk);
    #1;
    chk("t3_cpu_first_stall", cpu_stall, 0);
    chk("t3_cpu_first_addr", ram_addr, 7);
    chk("t3_cpu_first_done", dma_done, 0);
    chk("t3_cpu_first_busy", dma_busy, 0);
`ifdef VRAM_ADDR_CHECK_EN
    chk("t2_addr_err", addr_err, 1);
`endif
    @(negedge clk);
    cpu_req = 1'b0; dma_req = 1'b0;
    #1;
    chk("t3_idle_we", ram_we, 0);
    chk("t3_idle_busy", dma_busy, 0);
    @(negedge clk);
    @(negedge clk);

    // CPU read of 10, then DMA read burst of 2 at 20, then CPU reads of burst data
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd10;
    #1;
    chk("t4_c0_stall", cpu_stall, 0);
    chk("t4_c0_addr", ram_addr, 10);
    @(negedge clk);
    cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_base = 17'd20; dma_len = 8'd2;
    #1;
    chk("t4_c1_beat", dma_beat, 0);
    chk("t4_c1_crv", cpu_rvalid, 0);
    @(negedge clk);
    dma_req = 1'b0;
    #1;
    chk("t4_c2_beat", dma_beat, 1);
    chk("t4_c2_addr", ram_addr, 20);
    chk("t4_c2_we", ram_we, 0);
    chk("t4_c2_crv", cpu_rvalid, 1);
    chk("t4_c2_crdata", cpu_rdata, pat(10));
    chk("t4_c2_drv", dma_rvalid, 0);
    @(negedge clk);
    #1;
    chk("t4_c3_addr", ram_addr, 21);
    chk("t4_c3_crv", cpu_rvalid, 0);
    chk("t4_c3_drv", dma_rvalid, 0);
    @(negedge clk);
    #1;
    chk("t4_c4_done", dma_done, 1);
    chk("t4_c4_drv", dma_rvalid, 1);
    chk("t4_c4_drdata", dma_rdata, pat(20));
    chk("t4_c4_crv", cpu_rvalid, 0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd0;
    #1;
    chk("t4_c5_stall", cpu_stall, 0);
    chk("t4_c5_addr", ram_addr, 0);
    chk("t4_c5_drv", dma_rvalid, 1);
    chk("t4_c5_drdata", dma_rdata, pat(21));
    chk("t4_c5_crv", cpu_rvalid, 0);
    @(negedge clk);
    cpu_addr = 17'h1FFFF;
    #1;
    chk("t4_c6_drv", dma_rvalid, 0);
    chk("t4_c6_drdata_hold", dma_rdata, pat(21));
    chk("t4_c6_crv", cpu_rvalid, 0);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("t4_c7_crv", cpu_rvalid, 1);
    chk("t4_c7_crdata", cpu_rdata, 32'hCAFE_0002);
    chk("t4_c7_drv", dma_rvalid, 0);
    @(negedge clk);
    #1;
    chk("t4_c8_crv", cpu_rvalid, 1);
    chk("t4_c8_crdata", cpu_rdata, CHK ? 32'h0 : 32'hCAFE_0001);

    // dma_len = 0 runs 256 beats
    @(negedge clk);
    dma_req = 1'b1; dma_we = 1'b1; dma_base = 17'h100; dma_len = 8'd0; dma_wdata = '0;
    #1;
    chk("t5_start_beat", dma_beat, 0);
    nb = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      @(negedge clk);
      dma_req = 1'b0;
      #1;
      if (dma_beat) nb++;
      if (dma_done) seen_done = 1'b1;
    end
    chk("t5_beats", 64'(nb), 256);
    chk("t5_done_seen", seen_done, 1);

    // Reset in the third beat of an 8-beat read burst
    @(negedge clk);
    dma_req = 1'b1; dma_we = 1'b0; dma_base = 17'd40; dma_len = 8'd8;
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dma_req = 1'b0;
      #1;
      chk("t6_beat", dma_beat, 1);
      chk("t6_beat_addr", ram_addr, 40 + k);
    end
    chk("t6_pre_drv", dma_rvalid, 1);
    chk("t6_pre_drdata", dma_rdata, pat(40));
    reset = 1'b1;
    #1;
    chk("t6_rst_beat", dma_beat, 0);
    chk("t6_rst_busy", dma_busy, 0);
    chk("t6_rst_addr", ram_addr, 0);
    chk("t6_rst_we", ram_we, 0);
    chk("t6_rst_drv", dma_rvalid, 0);
    chk("t6_rst_drdata", dma_rdata, 0);
    chk("t6_rst_crdata", cpu_rdata, 0);
    chk("t6_rst_done", dma_done, 0);
`ifdef VRAM_ADDR_CHECK_EN
    chk("t6_rst_addr_err", addr_err, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t6_post_drv", dma_rvalid, 0);
      chk("t6_post_done", dma_done, 0);
      chk("t6_post_busy", dma_busy, 0);
      @(negedge clk);
    end

`ifdef VRAM_ADDR_CHECK_EN
    // Out-of-range CPU write and read
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'd76800; cpu_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t7_wr_we", ram_we, 0);
    chk("t7_err_before", addr_err, 0);
    chk("t7_wr_stall", cpu_stall, 0);
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    chk("t7_err_set", addr_err, 1);
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    #1;
    chk("t7_rd_rv", cpu_rvalid, 1);
    chk("t7_rd_data", cpu_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t7_err_sticky", addr_err, 1);
    reset = 1'b1;
    #1;
    chk("t7_err_reset", addr_err, 0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
